// File: rtl/spi_slave_trx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_trx
// Brief    : SPI mode-0 slave byte transceiver. It synchronises sck/mosi/ss
//            into clk, deserialises MOSI bytes and serialises the engine's
//            response byte onto MISO. It holds the engine in reset while
//            the slave is deselected.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_trx #(
  parameter logic [7:0] IDLE_TX = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       rst_o,
  output logic [7:0] data_o,
  output logic       ack_pop_o,
  input  logic [7:0] data_i,
  input  logic       ack_i
);

  // Two-stage synchronisers; index 0 is the first stage
  logic [1:0] sck_sync;
  logic [1:0] mosi_sync;
  logic [1:0] ss_sync;
  logic       sck_hist;
  logic       ss_hist;

  logic       mosi_s;
  logic       sel;
  logic       sck_rise;
  logic       sck_fall;
  logic       ss_fall;

  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] tx_buf;
  logic       tx_buf_valid;

  // Bring the pins into clk and keep one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      ss_sync   <= 2'b11;
      sck_hist  <= 1'b0;
      ss_hist   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_sync   <= {ss_sync[0], ss};
      sck_hist  <= sck_sync[1];
      ss_hist   <= ss_sync[1];
    end
  end

  assign mosi_s   = mosi_sync[1];
  assign sel      = ~ss_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_hist;
  assign sck_fall = ~sck_sync[1] & sck_hist;
  assign ss_fall  = ~ss_sync[1] & ss_hist;

  // Engine reset follows the synchronised deselect state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_o <= 1'b1;
    end else begin
      rst_o <= ~sel;
    end
  end

  // Receive shifter and bit counter; cleared whenever deselected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sr   <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (!sel) begin
      rx_sr   <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      rx_sr   <= {rx_sr[6:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Publish a completed byte with a single-cycle strobe on the eighth rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o    <= 8'h00;
      ack_pop_o <= 1'b0;
    end else begin
      ack_pop_o <= sel & sck_rise & (bit_cnt == 3'd7);
      if (sel && sck_rise && (bit_cnt == 3'd7)) begin
        data_o <= {rx_sr[6:0], mosi_s};
      end
    end
  end

  // Response buffer and transmit shifter; a strobe coinciding with the
  // byte-boundary load bypasses the buffer and goes straight to the shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr        <= IDLE_TX;
      tx_buf       <= 8'h00;
      tx_buf_valid <= 1'b0;
    end else if (!sel) begin
      tx_sr        <= IDLE_TX;
      tx_buf_valid <= 1'b0;
    end else begin
      if (ack_i) begin
        tx_buf       <= data_i;
        tx_buf_valid <= 1'b1;
      end
      if (ss_fall) begin
        tx_sr <= IDLE_TX;
      end else if (sck_fall) begin
        if (bit_cnt == 3'd0) begin
          if (ack_i) begin
            tx_sr <= data_i;
          end else if (tx_buf_valid) begin
            tx_sr <= tx_buf;
          end else begin
            tx_sr <= IDLE_TX;
          end
          tx_buf_valid <= 1'b0;
        end else begin
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  assign miso = sel ? tx_sr[7] : 1'b0;

endmodule
`default_nettype wire
